// File: rtl/ship_ctrl.sv
// Player-ship controller: movement with edge clamping, fire cooldown, lives and
// a hit/explode/respawn/dead sequence, plus a registered sprite pixel enable.
//
// state   | meaning
// --------+------------------------------------------------------------
// ALIVE   | normal play; move and fire; hit starts an explosion
// EXPLODE | explosion bitmap shown, inputs frozen, counts down frames
// RESPAWN | back at spawn X, blinking, move/fire allowed, hit ignored
// DEAD    | no lives left, sprite hidden, waits for restart
module ship_ctrl #(
   parameter int X_RESET        = 312,
   parameter int Y_POS          = 440,
   parameter int SPEED          = 4,
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 640,
   parameter int LIVES          = 3,
   parameter int EXPLODE_FRAMES = 32,
   parameter int RESPAWN_FRAMES = 60,
   parameter int FIRE_COOLDOWN  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       fire_btn,
   input  logic       hit,
   input  logic       restart,
   input  logic [1:0] scale,
   output logic [9:0] ship_x_pos,
   output logic       ship_on,
   output logic       fire,
   output logic [9:0] fire_x,
   output logic [2:0] lives,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_ALIVE   = 2'd0,
      ST_EXPLODE = 2'd1,
      ST_RESPAWN = 2'd2,
      ST_DEAD    = 2'd3
   } state_t;

   localparam logic [11:0] X_RESET_L = 12'(X_RESET);
   localparam logic [11:0] Y_POS_L   = 12'(Y_POS);
   localparam logic [11:0] SPEED_L   = 12'(SPEED);
   localparam logic [11:0] X_MIN_L   = 12'(X_MIN);
   localparam logic [11:0] X_MAX_L   = 12'(X_MAX);
   localparam logic [2:0]  LIVES_L   = 3'(LIVES);
   localparam logic [15:0] EXP_L     = 16'(EXPLODE_FRAMES);
   localparam logic [15:0] RESP_L    = 16'(RESPAWN_FRAMES);
   localparam logic [15:0] COOL_L    = 16'(FIRE_COOLDOWN);

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [2:0]  lives_q, lives_d;
   logic [15:0] ctr_q, ctr_d;
   logic [15:0] cool_q, cool_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic        ship_on_q, ship_on_d;
   logic        fire_q, fire_d;
   logic [9:0]  fire_x_q, fire_x_d;

   logic [11:0] w, h, x_ext, x_mv, px, py;
   logic        can_act, in_box, blank;
   logic [2:0]  row;
   logic [3:0]  col;
   logic [15:0] bits;

   function automatic logic [15:0] ship_row(input logic [2:0] r);
      logic [15:0] v;
      unique case (r)
         3'd0:    v = 16'h0040;
         3'd1:    v = 16'h00E0;
         3'd2:    v = 16'h00E0;
         3'd3:    v = 16'h0FFE;
         default: v = 16'h1FFF;
      endcase
      return v;
   endfunction

   function automatic logic [15:0] explode_row(input logic [2:0] r);
      logic [15:0] v;
      unique case (r)
         3'd0:    v = 16'h1111;
         3'd1:    v = 16'h0AAA;
         3'd2:    v = 16'h0444;
         3'd3:    v = 16'h1B5B;
         3'd4:    v = 16'h0444;
         3'd5:    v = 16'h0AAA;
         3'd6:    v = 16'h1111;
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

   always_comb begin
      w     = 12'd13 << scale;
      h     = 12'd8 << scale;
      x_ext = {2'b00, x_q};
      px    = {2'b00, pix_x};
      py    = {2'b00, pix_y};

      // Movement, then a clamp that also catches a scale change past the edge.
      x_mv = x_ext;
      if (move_left && !move_right) begin
         x_mv = (x_ext >= X_MIN_L + SPEED_L) ? x_ext - SPEED_L : X_MIN_L;
      end else if (move_right && !move_left) begin
         x_mv = (x_ext + SPEED_L + w <= X_MAX_L) ? x_ext + SPEED_L : X_MAX_L - w;
      end
      if (x_mv + w > X_MAX_L) begin
         x_mv = X_MAX_L - w;
      end

      // A hit in ALIVE pre-empts movement and fire on the same tick.
      can_act = (state_q == ST_ALIVE && !hit) || (state_q == ST_RESPAWN);

      state_d  = state_q;
      x_d      = x_q;
      lives_d  = lives_q;
      ctr_d    = ctr_q;
      cool_d   = cool_q;
      fcnt_d   = fcnt_q;
      fire_d   = 1'b0;
      fire_x_d = fire_x_q;

      if (frame_tick) begin
         fcnt_d = fcnt_q + 3'd1;
         if (can_act) begin
            x_d = 10'(x_mv);
         end
         if (can_act && fire_btn && cool_q == 16'd0) begin
            fire_d   = 1'b1;
            fire_x_d = 10'(x_ext + (w >> 1));
            cool_d   = COOL_L;
         end else if (cool_q != 16'd0) begin
            cool_d = cool_q - 16'd1;
         end
      end

      unique case (state_q)
         ST_ALIVE: begin
            if (hit) begin
               lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
               ctr_d   = EXP_L;
               state_d = ST_EXPLODE;
            end
         end
         ST_EXPLODE: begin
            if (frame_tick) begin
               if (ctr_q <= 16'd1) begin
                  if (lives_q == 3'd0) begin
                     ctr_d   = 16'd0;
                     state_d = ST_DEAD;
                  end else begin
                     x_d     = 10'(X_RESET_L);
                     ctr_d   = RESP_L;
                     state_d = ST_RESPAWN;
                  end
               end else begin
                  ctr_d = ctr_q - 16'd1;
               end
            end
         end
         ST_RESPAWN: begin
            if (frame_tick) begin
               if (ctr_q <= 16'd1) begin
                  ctr_d   = 16'd0;
                  state_d = ST_ALIVE;
               end else begin
                  ctr_d = ctr_q - 16'd1;
               end
            end
         end
         ST_DEAD: begin
            if (restart) begin
               lives_d = LIVES_L;
               x_d     = 10'(X_RESET_L);
               state_d = ST_ALIVE;
            end
         end
         default: state_d = ST_ALIVE;
      endcase

      // Pixel lookup: column 0 of the sprite is bitmap bit 12.
      in_box = (px >= x_ext) && (px < x_ext + w) &&
               (py >= Y_POS_L) && (py < Y_POS_L + h);
      row    = 3'((py - Y_POS_L) >> scale);
      col    = 4'd12 - 4'((px - x_ext) >> scale);
      bits   = (state_q == ST_EXPLODE) ? explode_row(row) : ship_row(row);
      blank  = (state_q == ST_DEAD) || (state_q == ST_RESPAWN && fcnt_q[2]);
      ship_on_d = in_box && !blank && bits[col];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ALIVE;
         x_q       <= 10'(X_RESET_L);
         lives_q   <= LIVES_L;
         ctr_q     <= 16'd0;
         cool_q    <= 16'd0;
         fcnt_q    <= 3'd0;
         ship_on_q <= 1'b0;
         fire_q    <= 1'b0;
         fire_x_q  <= 10'd0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         lives_q   <= lives_d;
         ctr_q     <= ctr_d;
         cool_q    <= cool_d;
         fcnt_q    <= fcnt_d;
         ship_on_q <= ship_on_d;
         fire_q    <= fire_d;
         fire_x_q  <= fire_x_d;
      end
   end

   assign ship_x_pos = x_q;
   assign ship_on    = ship_on_q;
   assign fire       = fire_q;
   assign fire_x     = fire_x_q;
   assign lives      = lives_q;
   assign game_over  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_ship_ctrl.sv
// Self-checking bench for ship_ctrl: vector table, movement/fire scoreboard,
// hit/explode/respawn/dead sequences and a scale-2 sprite sweep.
module tb_ship_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, frame_tick, move_left, move_right, fire_btn, hit, restart;
   logic [9:0] pix_x, pix_y;
   logic [1:0] scale;
   logic [9:0] ship_x_pos, fire_x;
   logic       ship_on, fire, game_over;
   logic [2:0] lives;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       ml, mr, fb;
      logic [1:0] sc;
      int         exp_x;
      logic       exp_fire;
      int         exp_fx;
   } vec_t;

   typedef struct {
      int   x;
      logic f;
      int   fx;
   } exp_t;

   exp_t sbq[$];
   logic pixq[$];

   ship_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .pix_x(pix_x), .pix_y(pix_y),
      .move_left(move_left), .move_right(move_right), .fire_btn(fire_btn),
      .hit(hit), .restart(restart), .scale(scale),
      .ship_x_pos(ship_x_pos), .ship_on(ship_on), .fire(fire), .fire_x(fire_x),
      .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic int mdl_x(input int x, input logic ml, input logic mr, input int w);
      int r;
      r = x;
      if (ml && !mr) r = (x >= 4) ? x - 4 : 0;
      else if (mr && !ml) r = (x + 4 + w <= 640) ? x + 4 : 640 - w;
      if (r + w > 640) r = 640 - w;
      return r;
   endfunction

   task automatic frame(input logic ml, input logic mr, input logic fb,
                        input logic [1:0] sc, input logic chk_en, input exp_t e);
      @(negedge clk);
      move_left = ml; move_right = mr; fire_btn = fb; scale = sc; frame_tick = 1'b1;
      if (chk_en) sbq.push_back(e);
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (chk_en) begin
         exp_t g;
         g = sbq.pop_front();
         chk("x_pos", int'(ship_x_pos), g.x);
         chk("fire", int'(fire), int'(g.f));
         if (g.f) begin
            chk("fire_x", int'(fire_x), g.fx);
            @(posedge clk); #1;
            chk("fire_one_clk", int'(fire), 0);
         end
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic frames(input int n, input logic ml, input logic mr);
      exp_t none;
      none = '{0, 1'b0, 0};
      for (int i = 0; i < n; i++) frame(ml, mr, 1'b0, scale, 1'b0, none);
   endtask

   task automatic hit_pulse(input string nm, input int exp_lives);
      @(negedge clk); hit = 1'b1;
      @(posedge clk); #1; hit = 1'b0;
      chk(nm, int'(lives), exp_lives);
   endtask

   task automatic restart_pulse;
      @(negedge clk); restart = 1'b1;
      @(posedge clk); #1; restart = 1'b0;
   endtask

   task automatic pix_chk(input string nm, input int px, input int py, input int exp);
      @(negedge clk); pix_x = 10'(px); pix_y = 10'(py);
      @(posedge clk); #1;
      chk(nm, int'(ship_on), exp);
   endtask

   initial begin
      vec_t tv[8];
      int   xm, ons;
      logic ef;
      logic [15:0] ship_bm[8];
      logic [15:0] rowv;

      ship_bm = '{16'h0040, 16'h00E0, 16'h00E0, 16'h0FFE,
                  16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h1FFF};
      tv[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 316, 1'b0, 0};
      tv[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 320, 1'b0, 0};
      tv[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 320, 1'b0, 0};
      tv[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 320, 1'b0, 0};
      tv[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 316, 1'b0, 0};
      tv[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 316, 1'b1, 322};
      tv[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 312, 1'b0, 0};
      tv[7] = '{1'b0, 1'b1, 1'b0, 2'd3, 316, 1'b0, 0};

      rst_n = 1'b0; frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
      fire_btn = 1'b0; hit = 1'b0; restart = 1'b0; scale = 2'd0;
      pix_x = 10'd0; pix_y = 10'd0;
      repeat (3) @(posedge clk); #1;
      chk("rst_x", int'(ship_x_pos), 312);
      chk("rst_lives", int'(lives), 3);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_ship_on", int'(ship_on), 0);
      chk("rst_fire", int'(fire), 0);
      chk("rst_fire_x", int'(fire_x), 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         frame(tv[i].ml, tv[i].mr, tv[i].fb, tv[i].sc, 1'b1,
               '{tv[i].exp_x, tv[i].exp_fire, tv[i].exp_fx});

      // Right edge at scale 0, then scale 1 pulls x back inside.
      xm = 316;
      for (int i = 0; i < 100; i++) begin
         xm = mdl_x(xm, 1'b0, 1'b1, 13);
         frame(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, '{xm, 1'b0, 0});
      end
      chk("x_right_stop", int'(ship_x_pos), 627);
      frame(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, '{614, 1'b0, 0});

      xm = 614;
      for (int i = 0; i < 152; i++) begin
         xm = mdl_x(xm, 1'b1, 1'b0, 13);
         frame(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, '{xm, 1'b0, 0});
      end
      chk("x_left_at_6", int'(ship_x_pos), 6);
      frame(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, '{2, 1'b0, 0});
      frame(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, '{0, 1'b0, 0});
      frame(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, '{0, 1'b0, 0});
      frame(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '{0, 1'b0, 0});

      // Asynchronous reset in the middle of a cycle.
      @(posedge clk); #3; rst_n = 1'b0; #1;
      chk("arst_x", int'(ship_x_pos), 312);
      chk("arst_fire_x", int'(fire_x), 0);
      chk("arst_lives", int'(lives), 3);
      @(negedge clk); rst_n = 1'b1;

      for (int f = 1; f <= 40; f++) begin
         ef = ((f - 1) % 17 == 0);
         frame(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, '{312, ef, 318});
      end

      frame(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, '{316, 1'b0, 0});
      frame(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, '{320, 1'b0, 0});

      hit_pulse("hit1_lives", 2);
      chk("hit1_game_over", int'(game_over), 0);
      pix_chk("explode_px_on", 320, 440, 1);
      pix_chk("explode_px_off", 326, 440, 0);
      frames(31, 1'b0, 1'b1);
      chk("explode_hold_x", int'(ship_x_pos), 320);
      pix_chk("explode_tick31", 320, 440, 1);
      frame(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, '{312, 1'b0, 0});

      @(negedge clk); pix_x = 10'd318; pix_y = 10'd440; move_right = 1'b0;
      ons = 0;
      for (int i = 0; i < 8; i++) begin
         frame(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '{0, 1'b0, 0});
         ons += int'(ship_on);
      end
      chk("blink_on_count", ons, 4);
      hit_pulse("hit_ignored_blink", 2);
      frames(51, 1'b0, 1'b0);
      hit_pulse("hit_ignored_last_blink", 2);
      frames(1, 1'b0, 1'b0);
      hit_pulse("hit_after_blink", 1);

      frames(32, 1'b0, 1'b0);
      frames(60, 1'b0, 1'b0);
      restart_pulse();
      chk("restart_ignored", int'(lives), 1);

      // Final hit arrives together with a frame tick, move and fire.
      @(negedge clk);
      hit = 1'b1; frame_tick = 1'b1; move_right = 1'b1; fire_btn = 1'b1;
      @(posedge clk); #1;
      hit = 1'b0; frame_tick = 1'b0; move_right = 1'b0; fire_btn = 1'b0;
      chk("hit3_lives", int'(lives), 0);
      chk("hit_tick_no_move", int'(ship_x_pos), 312);
      chk("hit_tick_no_fire", int'(fire), 0);
      frames(31, 1'b0, 1'b0);
      chk("explode_before_dead", int'(game_over), 0);
      frames(1, 1'b0, 1'b0);
      chk("dead_game_over", int'(game_over), 1);
      pix_chk("dead_ship_on", 312, 440, 0);

      restart_pulse();
      chk("restart_lives", int'(lives), 3);
      chk("restart_game_over", int'(game_over), 0);
      chk("restart_x", int'(ship_x_pos), 312);

      scale = 2'd2;
      for (int py = 436; py < 476; py++) begin
         for (int px = 308; px < 368; px++) begin
            logic e;
            @(negedge clk); pix_x = 10'(px); pix_y = 10'(py);
            e = 1'b0;
            if (px >= 312 && px < 364 && py >= 440 && py < 472) begin
               rowv = ship_bm[(py - 440) >> 2];
               e = rowv[12 - ((px - 312) >> 2)];
            end
            pixq.push_back(e);
            @(posedge clk); #1;
            chk("sweep_ship_on", int'(ship_on), int'(pixq.pop_front()));
         end
      end
      pix_chk("px_x24_on", 336, 440, 1);
      pix_chk("px_x0_off", 312, 440, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
